// File: rtl/bitwise_op_identifier.sv
// Receiver-side checker for the NOT/AND/OR/XOR/XNOR op unit: evaluates one op per
// clock against a captured (x, y, r) triple and reports which ops reproduce r.
module bitwise_op_identifier #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       op_match,
  output logic [2:0]       op_id,
  output logic [2:0]       match_count,
  output logic             none_flag,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [2:0]       idx;
  logic [4:0]       mask;
  logic [WIDTH-1:0] x_reg, y_reg, r_reg;

  logic [WIDTH-1:0] op_res;
  logic [4:0]       mask_next;
  logic [2:0]       id_next;
  logic [2:0]       cnt_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op_res = ~(x_reg ^ y_reg);
    case (idx)
      3'd0:    op_res = ~x_reg;
      3'd1:    op_res = x_reg & y_reg;
      3'd2:    op_res = x_reg | y_reg;
      3'd3:    op_res = x_reg ^ y_reg;
      default: op_res = ~(x_reg ^ y_reg);
    endcase
  end

  assign mask_next = mask | (5'(op_res == r_reg) << idx);

  // Lowest set index (descending scan so the lowest wins) and popcount of the final mask.
  always_comb begin
    id_next  = 3'd7;
    cnt_next = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (mask_next[k]) id_next = 3'(k);
      cnt_next = cnt_next + 3'(mask_next[k]);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);

  // NOTE: operand registers carry no reset; they are always loaded on accept before
  // being read, and keeping them out of the reset branch avoids a reset-gated enable.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      x_reg <= x;
      y_reg <= y;
      r_reg <= r;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      mask        <= 5'd0;
      op_match    <= 5'd0;
      op_id       <= 3'd7;
      match_count <= 3'd0;
      none_flag   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mask  <= 5'd0;
            idx   <= 3'd0;
            state <= EVAL;
          end
        end
        EVAL: begin
          mask <= mask_next;
          idx  <= idx + 3'd1;
          if (idx == 3'd4) begin
            op_match    <= mask_next;
            op_id       <= id_next;
            match_count <= cnt_next;
            none_flag   <= (mask_next == 5'd0);
            if (mask_next == 5'd0 && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_op_identifier.sv
// Scoreboard bench for bitwise_op_identifier; a second instance with CNT_W=2 shares
// all inputs so counter saturation can be observed on the same traffic.
module tb_bitwise_op_identifier;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [3:0] x, y, r;

  logic       in_ready, out_valid, none_flag;
  logic [4:0] op_match;
  logic [2:0] op_id, match_count;
  logic [7:0] err_cnt;

  logic       in_ready_s, out_valid_s, none_flag_s;
  logic [4:0] op_match_s;
  logic [2:0] op_id_s, match_count_s;
  logic [1:0] err_cnt_s;

  bitwise_op_identifier #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .op_match(op_match), .op_id(op_id), .match_count(match_count),
    .none_flag(none_flag), .err_cnt(err_cnt)
  );

  bitwise_op_identifier #(.WIDTH(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .x(x), .y(y), .r(r), .out_valid(out_valid_s), .out_ready(out_ready),
    .op_match(op_match_s), .op_id(op_id_s), .match_count(match_count_s),
    .none_flag(none_flag_s), .err_cnt(err_cnt_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] mask;
    logic [2:0] id;
    logic [2:0] cnt;
    logic       none;
    logic [7:0] err;
    logic [1:0] err_s;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   model_err = 0;

  function automatic logic [3:0] ref_op(input int k, input logic [3:0] a, input logic [3:0] b);
    case (k)
      0:       return ~a;
      1:       return a & b;
      2:       return a | b;
      3:       return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic exp_t predict(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    exp_t e;
    e.mask = '0;
    e.id   = 3'd7;
    e.cnt  = '0;
    for (int k = 0; k < 5; k++) e.mask[k] = (ref_op(k, a, b) == c);
    for (int k = 0; k < 5; k++) begin
      if (e.mask[k]) begin
        e.cnt = e.cnt + 3'd1;
        if (e.id == 3'd7) e.id = 3'(k);
      end
    end
    e.none = (e.mask == 5'd0);
    if (e.none) model_err++;
    e.err   = (model_err > 255) ? 8'd255 : 8'(model_err);
    e.err_s = (model_err > 3)   ? 2'd3   : 2'(model_err);
    return e;
  endfunction

  task automatic do_accept(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int waited = 0;
    x = a; y = b; r = c;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands after accept; the classification must use the captured copy.
    x = 4'($urandom); y = 4'($urandom); r = 4'($urandom);
    sb.push_back(predict(a, b, c));
  endtask

  task automatic collect(input int stall, input bit release_resp);
    exp_t        e;
    logic [19:0] snap;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL early_valid: out_valid=%b required 0 after 4 EVAL edges", out_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL latency: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_empty: got output with no expected entry");
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if ({op_match, op_id, match_count, none_flag, err_cnt} !== {e.mask, e.id, e.cnt, e.none, e.err}) begin
      n_err++;
      $display("FAIL result: got match=%b id=%0d cnt=%0d none=%b err=%0d required match=%b id=%0d cnt=%0d none=%b err=%0d",
               op_match, op_id, match_count, none_flag, err_cnt, e.mask, e.id, e.cnt, e.none, e.err);
    end
    n_vec++;
    if (err_cnt_s !== e.err_s) begin
      n_err++; $display("FAIL err_cnt_sat: got %0d required %0d", err_cnt_s, e.err_s);
    end
    snap = {op_match, op_id, match_count, none_flag, err_cnt};
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {op_match, op_id, match_count, none_flag, err_cnt} !== snap) begin
        n_err++;
        $display("FAIL stall_hold: out_valid=%b in_ready=%b outs=%h required 1/0 outs=%h",
                 out_valid, in_ready, {op_match, op_id, match_count, none_flag, err_cnt}, snap);
      end
    end
    if (release_resp) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; r = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, op_match, op_id, match_count, none_flag, err_cnt, err_cnt_s} !==
        {1'b0, 1'b1, 5'd0, 3'd7, 3'd0, 1'b0, 8'd0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_state: valid=%b ready=%b match=%b id=%0d cnt=%0d none=%b err=%0d required 0 1 00000 7 0 0 0",
               out_valid, in_ready, op_match, op_id, match_count, none_flag, err_cnt);
    end
  endtask

  task automatic test_directed();
    do_accept(4'b1010, 4'b0110, 4'b0101); collect(0, 1);  // NOT only
    do_accept(4'b1010, 4'b0110, 4'b1100); collect(0, 1);  // XOR only
    do_accept(4'b1010, 4'b0110, 4'b0011); collect(0, 1);  // XNOR only
    do_accept(4'b0000, 4'b0000, 4'b0000); collect(0, 1);  // AND, OR, XOR
  endtask

  task automatic test_no_match_saturation();
    for (int i = 0; i < 5; i++) begin
      do_accept(4'b1010, 4'b0110, 4'b1111);
      collect(0, 1);
    end
  endtask

  task automatic test_stall();
    do_accept(4'b1100, 4'b1010, 4'b1000);
    collect(3, 1);
  endtask

  task automatic test_back_to_back();
    do_accept(4'b0101, 4'b0011, 4'b0111);
    collect(0, 0);
    x = 4'b1111; y = 4'b0000; r = 4'b0000;
    in_valid = 1'b1; out_ready = 1'b1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_ready_in_resp: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_idle: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    do_accept(4'b1111, 4'b0000, 4'b0000);
    collect(0, 1);
  endtask

  task automatic test_mid_eval_reset();
    do_accept(4'b1010, 4'b0110, 4'b0101);
    void'(sb.pop_back());
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_err = 0;
    n_vec++;
    if ({out_valid, in_ready, op_match, op_id, match_count, none_flag, err_cnt, err_cnt_s} !==
        {1'b0, 1'b1, 5'd0, 3'd7, 3'd0, 1'b0, 8'd0, 2'd0}) begin
      n_err++;
      $display("FAIL mid_eval_reset: valid=%b ready=%b match=%b id=%0d cnt=%0d none=%b err=%0d required 0 1 00000 7 0 0 0",
               out_valid, in_ready, op_match, op_id, match_count, none_flag, err_cnt);
    end
    do_accept(4'b0011, 4'b0101, 4'b0001); collect(0, 1);
    do_accept(4'b0011, 4'b0101, 4'b1001); collect(1, 1);
  endtask

  task automatic test_random();
    logic [3:0] a, b, c;
    int pick;
    for (int i = 0; i < 12; i++) begin
      a = 4'($urandom); b = 4'($urandom);
      pick = $urandom_range(0, 5);
      c = (pick < 5) ? ref_op(pick, a, b) : 4'($urandom);
      do_accept(a, b, c);
      collect($urandom_range(0, 2), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_no_match_saturation();
    test_stall();
    test_back_to_back();
    test_mid_eval_reset();
    test_random();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
